// File: rtl/tcp_vlg_tx_scan.sv
// tcp_vlg_tx_scan -- retransmission / ACK scanner for the TCP TX path.
//
// Walks the packet-info RAM round-robin through its scan port. Each entry
// takes two cycles: S_RD drives the address, S_CHK evaluates the entry that
// the RAM returns one cycle later. Entries covered by the remote ACK are
// released (present cleared, free pulse). Entries whose timer expired are
// offered to the retransmitter and, once it accepts, rewritten with
// tries+1 and a fresh timestamp. An entry expiring with tries >= MAX_TRIES
// parks the scanner in a terminal failure state until reset.
//
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   en         connection established; scanning enabled
//   ack_num    latest remote acknowledgement number
//   ptr        scan address to the packet-info RAM
//   pkt_r      entry read at ptr, valid one cycle after ptr
//   pkt_w      entry write data, qualified by upd
//   upd        write pkt_w at ptr this cycle (1-cycle pulse)
//   free       one entry released this cycle (1-cycle pulse)
//   rtx_req    retransmission request (level, held until rtx_ack)
//   rtx_pkt    entry to retransmit, stable while rtx_req
//   rtx_ack    retransmitter accepted rtx_pkt
//   conn_fail  sticky connection failure

package tcp_vlg_tx_scan_pkg;
    localparam int PKT_TIM_W = 16;

    typedef struct packed {
        logic                 present;
        logic [31:0]          start;
        logic [31:0]          stop;   // seq of the byte after the last byte
        logic [PKT_TIM_W-1:0] tim;
        logic [7:0]           tries;
    } tcp_pkt_t;
endpackage

module tcp_vlg_tx_scan
    import tcp_vlg_tx_scan_pkg::*;
#(
    parameter int D         = 4,
    parameter int RTO_TICKS = 1000,
    parameter int MAX_TRIES = 5,
    parameter int TIM_W     = PKT_TIM_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [31:0]  ack_num,
    output logic [D-1:0] ptr,
    input  tcp_pkt_t     pkt_r,
    output tcp_pkt_t     pkt_w,
    output logic         upd,
    output logic         free,
    output logic         rtx_req,
    output tcp_pkt_t     rtx_pkt,
    input  logic         rtx_ack,
    output logic         conn_fail
);

    localparam logic [TIM_W-1:0] RTO_T   = TIM_W'(RTO_TICKS);
    localparam logic [7:0]       TRIES_T = 8'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_RD   = 2'd0,
        S_CHK  = 2'd1,
        S_RTX  = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [D-1:0]   r_ptr;
    logic [TIM_W-1:0] r_now;
    tcp_pkt_t       r_rtx_pkt;

    logic           w_ptr_inc;
    logic           w_rtx_load;
    logic [TIM_W-1:0] w_elapsed;
    logic           w_expired;
    logic [31:0]    w_ack_diff;
    logic           w_acked;
    logic           w_tries_max;

    // Both differences are modular, so timestamp and sequence wrap are
    // handled without special cases: an ACK covers the entry when it lies
    // in the half of sequence space at or ahead of stop.
    assign w_elapsed   = r_now - TIM_W'(pkt_r.tim);
    assign w_expired   = (w_elapsed >= RTO_T);
    assign w_ack_diff  = ack_num - pkt_r.stop;
    assign w_acked     = ~w_ack_diff[31];
    assign w_tries_max = (pkt_r.tries >= TRIES_T);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RD;
            r_ptr     <= '0;
            r_now     <= '0;
            r_rtx_pkt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_now   <= r_now + TIM_W'(1);
            if (w_ptr_inc) begin
                r_ptr <= r_ptr + D'(1);
            end
            if (w_rtx_load) begin
                r_rtx_pkt <= pkt_r;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_inc   = 1'b0;
        w_rtx_load  = 1'b0;
        upd         = 1'b0;
        free        = 1'b0;
        pkt_w       = pkt_r;

        case (r_state)
            S_RD: begin
                if (en) begin
                    w_state_nxt = S_CHK;
                end
            end

            S_CHK: begin
                if (!pkt_r.present) begin
                    w_ptr_inc   = 1'b1;
                    w_state_nxt = S_RD;
                end else if (w_acked) begin
                    upd           = 1'b1;
                    free          = 1'b1;
                    pkt_w.present = 1'b0;
                    w_ptr_inc     = 1'b1;
                    w_state_nxt   = S_RD;
                end else if (w_expired && w_tries_max) begin
                    w_state_nxt = S_FAIL;
                end else if (w_expired) begin
                    w_rtx_load  = 1'b1;
                    w_state_nxt = S_RTX;
                end else begin
                    w_ptr_inc   = 1'b1;
                    w_state_nxt = S_RD;
                end
            end

            // ptr is held here so the write-back lands on the entry that
            // was handed out; the ACK is deliberately not re-evaluated.
            S_RTX: begin
                if (rtx_ack) begin
                    upd         = 1'b1;
                    pkt_w       = r_rtx_pkt;
                    pkt_w.tries = r_rtx_pkt.tries + 8'd1;
                    pkt_w.tim   = PKT_TIM_W'(r_now);
                    w_ptr_inc   = 1'b1;
                    w_state_nxt = S_RD;
                end
            end

            S_FAIL: begin
                w_state_nxt = S_FAIL;
            end

            default: begin
                w_state_nxt = S_RD;
            end
        endcase
    end

    assign ptr       = r_ptr;
    assign rtx_pkt   = r_rtx_pkt;
    assign rtx_req   = (r_state == S_RTX);
    assign conn_fail = (r_state == S_FAIL);

endmodule

// File: tb/tb_tcp_vlg_tx_scan.sv
// Bench for tcp_vlg_tx_scan: packet-info RAM model with one-cycle read
// latency, randomized entry tables and ACK movement, and a procedural
// reference that walks the entries visit by visit.
module tb_tcp_vlg_tx_scan;
    import tcp_vlg_tx_scan_pkg::*;

    localparam int D     = 4;
    localparam int DEPTH = 16;
    localparam int RTO   = 1000;
    localparam int MAXT  = 5;

    logic           clk     = 1'b0;
    logic           rst     = 1'b1;
    logic           en      = 1'b0;
    logic [31:0]    ack_num = '0;
    logic           rtx_ack = 1'b0;
    logic [D-1:0]   ptr;
    tcp_pkt_t       pkt_r;
    tcp_pkt_t       pkt_w;
    tcp_pkt_t       rtx_pkt;
    logic           upd;
    logic           free;
    logic           rtx_req;
    logic           conn_fail;

    tcp_pkt_t       ram     [DEPTH];
    tcp_pkt_t       ref_mem [DEPTH];
    logic           ld_en  = 1'b0;
    logic [D-1:0]   ld_idx = '0;
    tcp_pkt_t       ld_val = '0;
    logic [15:0]    now_ref;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  en_rand    = 1'b0;
    bit  ack_force  = 1'b0;
    bit  ack_enable = 1'b1;
    bit  ack_walk   = 1'b0;

    tcp_vlg_tx_scan #(
        .D(D), .RTO_TICKS(RTO), .MAX_TRIES(MAXT), .TIM_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ack_num(ack_num), .ptr(ptr),
        .pkt_r(pkt_r), .pkt_w(pkt_w), .upd(upd), .free(free),
        .rtx_req(rtx_req), .rtx_pkt(rtx_pkt), .rtx_ack(rtx_ack),
        .conn_fail(conn_fail)
    );

    always #5 clk = ~clk;

    // Packet-info RAM: bench loads go through the same write port.
    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_idx] <= ld_val;
        end else if (upd) begin
            ram[ptr] <= pkt_w;
        end
        pkt_r <= ram[ptr];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) now_ref <= '0;
        else     now_ref <= now_ref + 16'd1;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_acked(input logic [31:0] ack, input logic [31:0] stop);
        longint d;
        d = longint'(ack) - longint'(stop);
        if (d < 0) d += 64'sh1_0000_0000;
        return d < 64'sh8000_0000;
    endfunction

    function automatic bit is_expired(input logic [15:0] now, input logic [15:0] tim);
        int el;
        el = int'(now) - int'(tim);
        if (el < 0) el += 65536;
        return el >= RTO;
    endfunction

    function automatic tcp_pkt_t mk(input bit pr, input logic [31:0] stop,
                                    input logic [15:0] tim, input logic [7:0] tries);
        tcp_pkt_t v;
        v.present = pr;
        v.stop    = stop;
        v.start   = stop - 32'd100;
        v.tim     = tim;
        v.tries   = tries;
        return v;
    endfunction

    task automatic expect_out(input int p, input bit e_upd, input bit e_free,
                              input bit e_rtx, input bit e_fail);
        check_eq("ptr",       128'(ptr),       128'(p));
        check_eq("upd",       128'(upd),       128'(e_upd));
        check_eq("free",      128'(free),      128'(e_free));
        check_eq("rtx_req",   128'(rtx_req),   128'(e_rtx));
        check_eq("conn_fail", 128'(conn_fail), 128'(e_fail));
    endtask

    task automatic step(output bit ab);
        @(posedge clk);
        #2;
        ab = rst;
    endtask

    // Reference: visits entries in order; each visit is one or more
    // address cycles (waiting for en) followed by a decision cycle.
    task automatic model_body();
        int       p;
        bit       ab;
        tcp_pkt_t e;
        tcp_pkt_t x;
        p = 0;
        forever begin
            do begin
                step(ab);
                if (ab) return;
                expect_out(p, 1'b0, 1'b0, 1'b0, 1'b0);
            end while (!en);
            step(ab);
            if (ab) return;
            e = ref_mem[p];
            if (e.present && is_acked(ack_num, e.stop)) begin
                expect_out(p, 1'b1, 1'b1, 1'b0, 1'b0);
                x = e;
                x.present = 1'b0;
                check_eq("pkt_w_release", 128'(pkt_w), 128'(x));
                ref_mem[p] = x;
            end else if (e.present && is_expired(now_ref, e.tim)) begin
                expect_out(p, 1'b0, 1'b0, 1'b0, 1'b0);
                if (int'(e.tries) >= MAXT) begin
                    forever begin
                        step(ab);
                        if (ab) return;
                        expect_out(p, 1'b0, 1'b0, 1'b0, 1'b1);
                    end
                end
                do begin
                    step(ab);
                    if (ab) return;
                    expect_out(p, rtx_ack, 1'b0, 1'b1, 1'b0);
                    check_eq("rtx_pkt", 128'(rtx_pkt), 128'(e));
                end while (!rtx_ack);
                x = e;
                x.tries = e.tries + 8'd1;
                x.tim   = now_ref;
                check_eq("pkt_w_rtx", 128'(pkt_w), 128'(x));
                ref_mem[p] = x;
            end else begin
                expect_out(p, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            p = (p + 1) % DEPTH;
        end
    endtask

    initial begin
        forever begin
            wait (!rst);
            model_body();
            wait (rst);
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (en_rand) en = ($urandom_range(0, 4) != 0);
            rtx_ack = ack_enable && rtx_req && (ack_force || ($urandom_range(0, 5) == 0));
            if (ack_walk && ($urandom_range(0, 15) == 0))
                ack_num = ack_num + 32'($urandom_range(0, 64));
        end
    endtask

    task automatic load(input int idx, input tcp_pkt_t v);
        ld_en  = 1'b1;
        ld_idx = D'(idx);
        ld_val = v;
        ref_mem[idx] = v;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic park();
        en_rand   = 1'b0;
        ack_walk  = 1'b0;
        en        = 1'b0;
        ack_force = 1'b1;
        run(6);
        ack_force = 1'b0;
        rtx_ack   = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ptr",       128'(ptr),       128'(0));
        check_eq("rst_upd",       128'(upd),       128'(0));
        check_eq("rst_free",      128'(free),      128'(0));
        check_eq("rst_rtx_req",   128'(rtx_req),   128'(0));
        check_eq("rst_conn_fail", 128'(conn_fail), 128'(0));
        check_eq("rst_rtx_pkt",   128'(rtx_pkt),   128'(0));
    endtask

    initial begin
        tcp_pkt_t    e0;
        logic [31:0] base;
        bit          seen;

        // Reset with an empty table.
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) load(i, '0);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle sweep over empty entries.
        en = 1'b1;
        run(40);

        // Exact ACK releases entry 3.
        park();
        ack_num = 32'h0000_1000;
        load(3, mk(1'b1, 32'h0000_1000, now_ref, 8'd0));
        en = 1'b1;
        run(40);
        check_eq("e3_released", 128'(ram[3].present), 128'(0));

        // Sequence wrap: pre-wrap ACK does not cover stop=0x10, post-wrap does.
        park();
        ack_num = 32'hFFFF_FFF0;
        load(5, mk(1'b1, 32'h0000_0010, now_ref, 8'd0));
        en = 1'b1;
        run(40);
        check_eq("e5_kept_prewrap", 128'(ram[5].present), 128'(1));
        ack_num = 32'h0000_0020;
        run(40);
        check_eq("e5_released_postwrap", 128'(ram[5].present), 128'(0));

        // Timeout and one retransmission of entry 2, then its release.
        park();
        load(2, mk(1'b1, 32'h0000_5000, now_ref, 8'd0));
        en = 1'b1;
        run(1100);
        check_eq("e2_tries", 128'(ram[2].tries), 128'(1));
        ack_num = 32'h0000_5000;
        run(40);
        check_eq("e2_released", 128'(ram[2].present), 128'(0));

        // Randomized tables, ACK movement and en toggling.
        for (int r = 0; r < 6; r++) begin
            park();
            base    = $urandom;
            ack_num = base;
            for (int i = 0; i < DEPTH; i++)
                load(i, mk($urandom_range(0, 3) != 0,
                           base + 32'($urandom_range(0, 200)) - 32'd100,
                           now_ref - 16'($urandom_range(0, 1200)),
                           8'($urandom_range(0, 4))));
            en_rand  = 1'b1;
            ack_walk = 1'b1;
            run(300);
        end

        // Expiry with the retry budget spent: terminal failure.
        park();
        ack_num = 32'h0000_0100;
        for (int i = 0; i < DEPTH; i++)
            load(i, (i == 7) ? mk(1'b1, 32'h0000_0900, now_ref - 16'd2000, 8'd5) : '0);
        en = 1'b1;
        run(60);
        check_eq("fail_sticky",  128'(conn_fail),      128'(1));
        check_eq("fail_no_rtx",  128'(rtx_req),        128'(0));
        check_eq("fail_ptr",     128'(ptr),            128'(7));
        check_eq("fail_e7_kept", 128'(ram[7].present), 128'(1));

        // Reset clears the failure; reset in the middle of a retransmission.
        rst = 1'b1;
        en  = 1'b0;
        run(2);
        check_reset_outputs();
        e0 = mk(1'b1, 32'h0000_9000, now_ref - 16'd1500, 8'd0);
        for (int i = 0; i < DEPTH; i++) load(i, (i == 0) ? e0 : '0);
        ack_num = 32'h0000_0020;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ack_enable = 1'b0;
        en = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            run(1);
            seen = rtx_req;
        end
        check_eq("rtx_before_rst", 128'(seen), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_drops_rtx_req", 128'(rtx_req), 128'(0));
        check_eq("rst_ptr_zero",      128'(ptr),     128'(0));
        check_eq("rst_no_upd",        128'(upd),     128'(0));
        run(2);
        check_eq("e0_unmodified", 128'(ram[0]), 128'(e0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
